// File: rtl/uart_mm_peripheral.sv
// Word-indexed UART register window with an 8N1 transmitter and receiver sharing one baud divisor.
// Reads are combinational (zero latency); a TX_DATA write while busy is dropped and flagged, never stalled.
module uart_mm_peripheral #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Select,
    input  logic        Write,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLK_FREQ / BAUD);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic [2:0] reg_sel;
    logic       wr_en, rd_en;
    logic       wr_tx, wr_baud, wr_clr, rd_rx;

    assign reg_sel = Addr[2:0];
    assign wr_en   = Select & Write;
    assign rd_en   = Select & ~Write;
    assign wr_tx   = wr_en && (reg_sel == 3'd0);
    assign wr_baud = wr_en && (reg_sel == 3'd3);
    assign wr_clr  = wr_en && (reg_sel == 3'd4);
    assign rd_rx   = rd_en && (reg_sel == 3'd2);

    logic unused_bits;
    assign unused_bits = ^{Addr, WData};

    logic [7:0]       tx_data;
    logic [7:0]       rx_byte;
    logic [DIV_W-1:0] baud_div;
    logic             rx_valid, rx_overrun, tx_dropped, rx_frame_err;

    // ---------------- transmitter ----------------
    uart_state_t      tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_accept, tx_drop, tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - ONE);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_accept  = 1'b0;
        case (tx_state)
            ST_START: begin
                tx_cnt_n = tx_cnt + ONE;
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    tx_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_cnt_n = tx_cnt + ONE;
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_cnt_n = tx_cnt + ONE;
                if (tx_bit_end) begin
                    tx_cnt_n   = '0;
                    tx_state_n = ST_IDLE;
                end
            end
            default: ;
        endcase
        // A write landing on the final stop-bit cycle is accepted back-to-back.
        if (wr_tx && tx_state_n == ST_IDLE) begin
            tx_accept  = 1'b1;
            tx_state_n = ST_START;
            tx_cnt_n   = '0;
            tx_div_n   = baud_div;
            tx_shift_n = WData[7:0];
        end
    end

    assign tx_drop = wr_tx & ~tx_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_div   <= RESET_DIV;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        case (tx_state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = tx_shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic             rx_s1, rx_s2, rx_prev;
    uart_state_t      rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_ok, rx_err, rx_bit_end;

    assign rx_bit_end = (rx_cnt == rx_div - ONE);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_ok      = 1'b0;
        rx_err     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_n = ST_START;
                    rx_cnt_n   = '0;
                    rx_div_n   = baud_div;
                end
            end
            ST_START: begin
                rx_cnt_n = rx_cnt + ONE;
                // Mid-start-bit check rejects short low glitches.
                if (rx_cnt == (rx_div >> 1) - ONE) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_cnt_n = rx_cnt + ONE;
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                rx_cnt_n = rx_cnt + ONE;
                if (rx_bit_end) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_IDLE;
                    rx_ok      = rx_s2;
                    rx_err     = ~rx_s2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_div   <= RESET_DIV;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // ---------------- registers and status ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data      <= 8'd0;
            rx_byte      <= 8'd0;
            baud_div     <= RESET_DIV;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_dropped   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (wr_tx) tx_data <= WData[7:0];
            if (rx_ok) rx_byte <= rx_shift;
            if (wr_baud) baud_div <= (WData[DIV_W-1:0] < TWO) ? TWO : WData[DIV_W-1:0];
            // Set events take priority over read-clear and CLEAR on the same edge.
            rx_valid     <= rx_ok | (rx_valid & ~rd_rx);
            rx_overrun   <= (rx_ok & rx_valid & ~rd_rx) | (rx_overrun & ~(wr_clr & WData[1]));
            tx_dropped   <= tx_drop | (tx_dropped & ~(wr_clr & WData[2]));
            rx_frame_err <= rx_err | (rx_frame_err & ~(wr_clr & WData[3]));
        end
    end

    always_comb begin
        RData = 32'd0;
        if (Select) begin
            case (reg_sel)
                3'd0:    RData = {24'd0, tx_data};
                3'd1:    RData = {27'd0, rx_frame_err, tx_dropped, rx_overrun, rx_valid,
                                  (tx_state != ST_IDLE)};
                3'd2:    RData = {24'd0, rx_byte};
                3'd3:    RData = 32'(baud_div);
                default: RData = 32'd0;
            endcase
        end
    end

endmodule
